// File: rtl/maze_pkg.sv
// Shared maze types: move directions, streamer FSM states and grid defaults.
package maze_pkg;

    // Default coordinate width: 16x16 maze.
    localparam int COORD_W_DEF = 4;

    // 2-bit move codes as stored in the solver's direction stack.
    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    // Path streamer sequencing: probe stack, strobe read, capture, hand off.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        READ  = 3'd2,
        LOAD  = 3'd3,
        EMIT  = 3'd4,
        FIN   = 3'd5
    } state_t;

endpackage

// File: rtl/coord_step.sv
// Applies one move to a (row, col) pair with wrap-around and reports
// whether the move stepped off the grid. Purely combinational; shared
// with the solver.
module coord_step
    import maze_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF
)(
    input  logic [COORD_W-1:0] i_row,
    input  logic [COORD_W-1:0] i_col,
    input  dir_t               i_dir,
    output logic [COORD_W-1:0] o_row,
    output logic [COORD_W-1:0] o_col,
    output logic               o_oob
);

    // Next coordinate; the edge test is done on the pre-move value so the
    // wrapped result never has to be compared back.
    always_comb begin
        o_row = i_row;
        o_col = i_col;
        o_oob = 1'b0;
        case (i_dir)
            UP: begin
                o_row = i_row - COORD_W'(1);
                o_oob = (i_row == '0);
            end
            RIGHT: begin
                o_col = i_col + COORD_W'(1);
                o_oob = (i_col == '1);
            end
            DOWN: begin
                o_row = i_row + COORD_W'(1);
                o_oob = (i_row == '1);
            end
            LEFT: begin
                o_col = i_col - COORD_W'(1);
                o_oob = (i_col == '0);
            end
            default: begin
                o_row = i_row;
                o_col = i_col;
                o_oob = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/path_streamer.sv
// Replays the solver's direction stack bottom-to-top, turning each move
// into absolute coordinates and streaming (dir,row,col) over valid/ready.
module path_streamer
    import maze_pkg::*;
#(
    parameter int WIDTH     = 2,
    parameter int COORD_W   = COORD_W_DEF,
    parameter int START_ROW = 0,
    parameter int START_COL = 0,
    parameter int CNT_W     = 8
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stk_all_read,
    input  logic [WIDTH-1:0]   stk_pout,
    output logic               stk_read,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_dir,
    output logic [COORD_W-1:0] out_row,
    output logic [COORD_W-1:0] out_col,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   step_count,
    output logic               oob
);

    localparam logic [COORD_W-1:0] ROW0 = COORD_W'(START_ROW);
    localparam logic [COORD_W-1:0] COL0 = COORD_W'(START_COL);

    state_t             r_state;
    state_t             w_next;

    // Running position (walk state) kept apart from the published tuple so
    // the outputs can reset to 0 independent of the start cell.
    logic [COORD_W-1:0] r_row;
    logic [COORD_W-1:0] r_col;
    logic [COORD_W-1:0] r_out_row;
    logic [COORD_W-1:0] r_out_col;
    logic [WIDTH-1:0]   r_dir;
    logic               r_last;
    logic               r_oob;
    logic [CNT_W-1:0]   r_step;

    logic [COORD_W-1:0] w_nrow;
    logic [COORD_W-1:0] w_ncol;
    logic               w_oob_hit;
    logic               w_start_ok;
    logic               w_accept;

    assign w_start_ok = (r_state == IDLE) && start;
    assign w_accept   = (r_state == EMIT) && out_ready;

    // stk_pout is only meaningful in LOAD, which is the only place the
    // stepped result is consumed.
    coord_step #(
        .COORD_W (COORD_W)
    ) u_step (
        .i_row (r_row),
        .i_col (r_col),
        .i_dir (dir_t'(stk_pout[1:0])),
        .o_row (w_nrow),
        .o_col (w_ncol),
        .o_oob (w_oob_hit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state and Moore strobes.
    always_comb begin
        w_next    = r_state;
        stk_read  = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next = CHECK;
            end
            CHECK: w_next = stk_all_read ? FIN : READ;
            READ: begin
                stk_read = 1'b1;
                w_next   = LOAD;
            end
            LOAD: w_next = EMIT;
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) w_next = r_last ? FIN : CHECK;
            end
            FIN: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Walk position, published tuple, step counter and sticky off-grid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row     <= ROW0;
            r_col     <= COL0;
            r_out_row <= '0;
            r_out_col <= '0;
            r_dir     <= '0;
            r_last    <= 1'b0;
            r_oob     <= 1'b0;
            r_step    <= '0;
        end else begin
            if (w_start_ok) begin
                r_row  <= ROW0;
                r_col  <= COL0;
                r_step <= '0;
                r_oob  <= 1'b0;
                r_last <= 1'b0;
            end
            if (r_state == LOAD) begin
                r_dir     <= stk_pout;
                r_row     <= w_nrow;
                r_col     <= w_ncol;
                r_out_row <= w_nrow;
                r_out_col <= w_ncol;
                // Read pointer has already moved past this entry.
                r_last    <= stk_all_read;
                if (w_oob_hit) r_oob <= 1'b1;
            end
            if (w_accept && (r_step != '1)) r_step <= r_step + CNT_W'(1);
        end
    end

    assign out_dir    = r_dir;
    assign out_row    = r_out_row;
    assign out_col    = r_out_col;
    assign out_last   = r_last;
    assign step_count = r_step;
    assign oob        = r_oob;

endmodule

// File: tb/tb_path_streamer.sv
// Bench for path_streamer: stack model, handshake monitor, table vectors,
// corner-case sequences and randomized paths against a coordinate model.
module tb_path_streamer;

    localparam int W  = 2;
    localparam int CW = 4;
    localparam int CN = 8;

    logic          clk = 1'b0;
    logic          rst, start, out_ready;
    logic          stk_all_read, stk_read, out_valid, out_last, busy, done, oob;
    logic [W-1:0]  stk_pout = '0;
    logic [W-1:0]  out_dir;
    logic [CW-1:0] out_row, out_col;
    logic [CN-1:0] step_count;

    always #5 clk = ~clk;

    path_streamer #(.WIDTH(W), .COORD_W(CW), .START_ROW(0), .START_COL(0), .CNT_W(CN)) dut (
        .clk(clk), .rst(rst), .start(start), .stk_all_read(stk_all_read),
        .stk_pout(stk_pout), .stk_read(stk_read), .out_valid(out_valid),
        .out_ready(out_ready), .out_dir(out_dir), .out_row(out_row),
        .out_col(out_col), .out_last(out_last), .busy(busy), .done(done),
        .step_count(step_count), .oob(oob)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- stack model ----------------
    logic [1:0] stk_mem [0:255];
    int         stk_n = 0;
    int         stk_rd = 0;
    logic       stk_clr = 1'b0;
    assign stk_all_read = (stk_rd == stk_n);

    always @(posedge clk) begin
        if (stk_clr) stk_rd <= 0;
        else if (stk_read) begin
            stk_pout <= stk_mem[8'(stk_rd)];
            stk_rd   <= stk_rd + 1;
        end
    end

    // ---------------- monitor ----------------
    typedef struct packed {
        logic [1:0] d;
        logic [3:0] r;
        logic [3:0] c;
        logic       l;
    } tup_t;

    tup_t got_q[$];
    int   cyc = 0;
    int   done_cnt, rd_cnt, rd_consec, stab_err, done_cyc, fv_cyc, stall_n;
    logic prev_rd, prev_stall;
    tup_t prev_t;
    logic mon_clr = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        tup_t t;
        t = '{out_dir, out_row, out_col, out_last};
        if (mon_clr) begin
            got_q.delete();
            done_cnt = 0; rd_cnt = 0; rd_consec = 0; stab_err = 0; stall_n = 0;
            done_cyc = -1; fv_cyc = -1; prev_rd = 1'b0; prev_stall = 1'b0; prev_t = '0;
        end else begin
            if (out_valid && fv_cyc < 0) fv_cyc = cyc;
            if (prev_stall && !(out_valid && t == prev_t)) stab_err++;
            if (stk_read) begin
                rd_cnt++;
                if (prev_rd) rd_consec++;
            end
            prev_rd = stk_read;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (out_valid && !out_ready && got_q.size() == 1) stall_n++;
            if (out_valid && out_ready) got_q.push_back(t);
            prev_stall = out_valid && !out_ready;
            prev_t = t;
        end
    end

    // ---------------- consumer ----------------
    // mode 0: always ready; 1: random; 2: hold tuple 2 off for 3 cycles
    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       out_ready = 1'($urandom_range(0, 1));
            2:       out_ready = !(out_valid && got_q.size() == 1 && stall_n < 3);
            default: out_ready = 1'b1;
        endcase
    end

    // ---------------- reference model ----------------
    logic [1:0] mv_q[$];
    tup_t       exp_q[$];
    bit         m_oob;
    int         t0;

    // Walk the moves in plain integers; off-grid means leaving 0..15.
    task automatic build_model();
        int r, c;
        r = 0; c = 0; m_oob = 0;
        exp_q.delete();
        foreach (mv_q[i]) begin
            case (mv_q[i])
                2'd0: r = r - 1;
                2'd1: c = c + 1;
                2'd2: r = r + 1;
                default: c = c - 1;
            endcase
            if (r < 0 || r > 15 || c < 0 || c > 15) m_oob = 1;
            r = (r + 16) % 16;
            c = (c + 16) % 16;
            exp_q.push_back('{mv_q[i], 4'(r), 4'(c), (i == mv_q.size() - 1)});
        end
    endtask

    task automatic load_stack(input int rmode);
        foreach (mv_q[i]) stk_mem[i] = mv_q[i];
        stk_n    = mv_q.size();
        stk_clr  = 1'b1;
        mon_clr  = 1'b1;
        rdy_mode = rmode;
        @(posedge clk); #1;
        stk_clr = 1'b0;
        mon_clr = 1'b0;
    endtask

    task automatic run_path(input bit repulse, input int rmode);
        int n;
        n = mv_q.size();
        load_stack(rmode);
        start = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #1;
            start = repulse && (i == 4);
            if (done_cnt > 0) break;
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        build_model();
        check("done_once", done_cnt, 1);
        check("tuple_count", got_q.size(), exp_q.size());
        for (int i = 0; i < n && i < got_q.size(); i++)
            check($sformatf("tuple[%0d]", i), got_q[i], exp_q[i]);
        check("step_count", step_count, n);
        check("oob", oob, m_oob);
        check("stk_reads", rd_cnt, n);
        check("read_not_consecutive", rd_consec, 0);
        check("tuple_stable", stab_err, 0);
        check("busy_after", busy, 0);
        if (n == 0) check("empty_done_latency", done_cyc - t0, 2);
        else begin
            check("first_valid_latency", fv_cyc - t0, 4);
            check("last_holds", out_last, 1);
            check("row_holds", out_row, exp_q[n-1].r);
            check("col_holds", out_col, exp_q[n-1].c);
        end
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        int          len;
        logic [15:0] mv;     // move i in mv[2*i+:2]
        int          e_row;
        int          e_col;
        int          e_steps;
        bit          e_oob;
    } vec_t;

    vec_t vt[5];

    initial begin
        vt[0] = '{0, 16'h0000,  0,  0, 0, 0};
        vt[1] = '{4, 16'h00A5,  2,  2, 4, 0};  // 01,01,10,10
        vt[2] = '{1, 16'h0000, 15,  0, 1, 1};  // 00
        vt[3] = '{1, 16'h0003,  0, 15, 1, 1};  // 11
        vt[4] = '{4, 16'h00C6,  0,  0, 4, 0};  // 10,01,00,11

        rst = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {out_valid, busy, done, stk_read, out_last, oob,
                                out_dir, out_row, out_col, step_count}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vt[k]) begin
            mv_q.delete();
            for (int i = 0; i < vt[k].len; i++) mv_q.push_back(vt[k].mv[2*i +: 2]);
            run_path(0, 0);
            check($sformatf("vec%0d_steps", k), step_count, vt[k].e_steps);
            check($sformatf("vec%0d_oob", k), oob, vt[k].e_oob);
            if (vt[k].len > 0) begin
                check($sformatf("vec%0d_row", k), out_row, vt[k].e_row);
                check($sformatf("vec%0d_col", k), out_col, vt[k].e_col);
            end
        end

        // Back-pressure on tuple 2.
        mv_q = '{2'd1, 2'd1, 2'd2, 2'd2};
        run_path(0, 2);

        // start re-pulsed mid-stream.
        mv_q = '{2'd1, 2'd2, 2'd1};
        run_path(1, 0);

        // Reset while tuple 2 is being offered.
        mv_q = '{2'd1, 2'd1, 2'd2, 2'd2};
        load_stack(2);
        start = 1'b1;
        begin
            bit hit;
            hit = 0;
            for (int i = 0; i < 100; i++) begin
                @(posedge clk); #1;
                start = 1'b0;
                if (out_valid && got_q.size() == 1) begin
                    hit = 1;
                    break;
                end
            end
            check("reached_emit2", hit, 1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrun_reset_outputs", {out_valid, busy, done, stk_read, out_last, oob,
                                       out_dir, out_row, out_col, step_count}, 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("no_done_after_reset", done_cnt, 0);
        run_path(0, 0);

        // Randomized paths with random back-pressure.
        for (int k = 0; k < 20; k++) begin
            int len;
            len = $urandom_range(0, 12);
            mv_q.delete();
            for (int i = 0; i < len; i++) mv_q.push_back(2'($urandom_range(0, 3)));
            run_path(0, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
